// File: rtl/qspi_responder_if.sv
// -----------------------------------------------------------------------------
// qspi_responder_if
// Purpose : Quad-SPI bus bundle between an initiator and the qspi_responder.
// Signals : cs_n      chip select, active low (initiator -> responder)
//           qspi_in   4-bit nibble from the initiator
//           qspi_out  4-bit nibble to the initiator
//           qspi_oe   responder output enable, all bits equal, 1 = drive
// Modports: master (initiator side), slave (responder side)
// -----------------------------------------------------------------------------
interface qspi_responder_if;
  logic       cs_n;
  logic [3:0] qspi_in;
  logic [3:0] qspi_out;
  logic [3:0] qspi_oe;

  modport master (output cs_n, output qspi_in, input qspi_out, input qspi_oe);
  modport slave  (input cs_n, input qspi_in, output qspi_out, output qspi_oe);
endinterface

// File: rtl/qspi_responder.sv
// -----------------------------------------------------------------------------
// qspi_responder
// Purpose : Target end of a quad-SPI link emulating one QSPI flash/PSRAM device,
//           backed by an internal byte array. Bus clock is clk; the bus is
//           sampled and driven on the rising edge.
// Ports   : clk        system / bus clock
//           reset      synchronous, active-high
//           bus        qspi_responder_if.slave (cs_n, qspi_in, qspi_out, qspi_oe)
//           load_we    backdoor write strobe
//           load_addr  backdoor byte address (AW bits)
//           load_data  backdoor byte
//           busy       high while cs_n is low and a transfer is in progress
//           cmd_err    one-cycle pulse on an unsupported command
// Config  : QSPI_RESP_WRITE_EN - when defined, command 0x38 writes memory
//           (PSRAM model); otherwise the device is read-only and 0x38 is an
//           unsupported command.
// Commands: 0xEB read (DUMMY turnaround cycles), 0x38 write (optional).
// -----------------------------------------------------------------------------
module qspi_responder #(
  parameter  int DEPTH = 1024,
  parameter  int DUMMY = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  qspi_responder_if.slave bus,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic          busy,
  output logic          cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_IGNORE
`ifdef QSPI_RESP_WRITE_EN
    , S_WDATA
`endif
  } state_t;

  state_t        r_state, w_state_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic [3:0]    r_cmd_hi, w_cmd_hi_next;
  logic [AW-1:0] r_addr, w_addr_next;
  logic          r_nib, w_nib_next;       // 0: next nibble is the high one
  logic [3:0]    r_out, w_out_next;
  logic          r_oe, w_oe_next;
  logic          r_cmd_err, w_cmd_err_next;
  logic          w_rd_en;
  logic [7:0]    r_rdata;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    w_cmd;
`ifdef QSPI_RESP_WRITE_EN
  logic          r_is_write, w_is_write_next;
  logic [3:0]    r_whi, w_whi_next;
  logic          w_wr_en;
`endif

  assign w_cmd       = {r_cmd_hi, bus.qspi_in};
  assign bus.qspi_out = r_out;
  assign bus.qspi_oe  = {4{r_oe}};
  assign cmd_err      = r_cmd_err;
  assign busy         = !bus.cs_n && (r_state != S_IDLE);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_cmd_hi_next  = r_cmd_hi;
    w_addr_next    = r_addr;
    w_nib_next     = r_nib;
    w_out_next     = r_out;
    w_oe_next      = r_oe;
    w_cmd_err_next = 1'b0;
    w_rd_en        = 1'b0;
`ifdef QSPI_RESP_WRITE_EN
    w_is_write_next = r_is_write;
    w_whi_next      = r_whi;
    w_wr_en         = 1'b0;
`endif
    if (bus.cs_n) begin
      // Deselect beats every other transition.
      w_state_next = S_IDLE;
      w_oe_next    = 1'b0;
      w_out_next   = 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cmd_hi_next = bus.qspi_in;
          w_state_next  = S_CMD;
        end
        S_CMD: begin
          w_cnt_next = 4'd0;
          if (w_cmd == 8'hEB) begin
            w_state_next = S_ADDR;
`ifdef QSPI_RESP_WRITE_EN
            w_is_write_next = 1'b0;
          end else if (w_cmd == 8'h38) begin
            w_state_next    = S_ADDR;
            w_is_write_next = 1'b1;
`endif
          end else begin
            w_state_next   = S_IGNORE;
            w_cmd_err_next = 1'b1;
          end
        end
        S_ADDR: begin
          // Shift in 24 address bits; only the low AW survive, so upper bits alias.
          w_addr_next = AW'({r_addr, bus.qspi_in});
          w_cnt_next  = r_cnt + 4'd1;
          if (r_cnt == 4'd5) begin
            w_cnt_next   = 4'd0;
            w_nib_next   = 1'b0;
            w_state_next = S_DUMMY;
`ifdef QSPI_RESP_WRITE_EN
            if (r_is_write) w_state_next = S_WDATA;
`endif
          end
        end
        S_DUMMY: begin
          w_cnt_next = r_cnt + 4'd1;
          if (r_cnt == 4'(DUMMY - 1)) begin
            // Fetch the first byte now so its high nibble is out next cycle.
            w_rd_en      = 1'b1;
            w_addr_next  = r_addr + AW'(1);
            w_nib_next   = 1'b0;
            w_state_next = S_RDATA;
          end
        end
        S_RDATA: begin
          w_oe_next = 1'b1;
          if (!r_nib) begin
            w_out_next = r_rdata[7:4];
            w_nib_next = 1'b1;
          end else begin
            // Low nibble leaves r_rdata while the next byte is fetched into it.
            w_out_next  = r_rdata[3:0];
            w_rd_en     = 1'b1;
            w_addr_next = r_addr + AW'(1);
            w_nib_next  = 1'b0;
          end
        end
`ifdef QSPI_RESP_WRITE_EN
        S_WDATA: begin
          if (!r_nib) begin
            w_whi_next = bus.qspi_in;
            w_nib_next = 1'b1;
          end else begin
            w_wr_en     = 1'b1;
            w_addr_next = r_addr + AW'(1);
            w_nib_next  = 1'b0;
          end
        end
`endif
        default: ; // S_IGNORE: wait for deselect
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_cmd_hi  <= 4'h0;
      r_addr    <= '0;
      r_nib     <= 1'b0;
      r_out     <= 4'h0;
      r_oe      <= 1'b0;
      r_cmd_err <= 1'b0;
`ifdef QSPI_RESP_WRITE_EN
      r_is_write <= 1'b0;
      r_whi      <= 4'h0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_cmd_hi  <= w_cmd_hi_next;
      r_addr    <= w_addr_next;
      r_nib     <= w_nib_next;
      r_out     <= w_out_next;
      r_oe      <= w_oe_next;
      r_cmd_err <= w_cmd_err_next;
`ifdef QSPI_RESP_WRITE_EN
      r_is_write <= w_is_write_next;
      r_whi      <= w_whi_next;
`endif
    end
  end

  // Backing store. The protocol write is placed last so it wins an address
  // collision with the backdoor on the same edge.
  always_ff @(posedge clk) begin
    if (load_we) r_mem[load_addr] <= load_data;
`ifdef QSPI_RESP_WRITE_EN
    if (w_wr_en && !reset) r_mem[r_addr] <= {r_whi, bus.qspi_in};
`endif
    if (w_rd_en) r_rdata <= r_mem[r_addr];
  end

endmodule
